// File: rtl/display_timings_480p.sv
// 640x480 @ 60 Hz timing generator in the pixel-clock domain.
// Outputs are registered and decoded from next-state counters, so they line up with sx/sy.
module display_timings_480p #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line
);
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_STA = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_STA = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

  logic [CORDW-1:0] sx_nx, sy_nx;

  // >= rather than == so a corrupted counter still falls back into range
  always_comb begin
    sx_nx = sx + CORDW'(1);
    sy_nx = sy;
    if (sx >= H_LAST) begin
      sx_nx = '0;
      sy_nx = (sy >= V_LAST) ? '0 : sy + CORDW'(1);
    end
  end

  // reset parks on the last blanking pixel so release lands on (0,0) with a frame strobe
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      sx    <= H_LAST;
      sy    <= V_LAST;
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      de    <= 1'b0;
      frame <= 1'b0;
      line  <= 1'b0;
    end else begin
      sx    <= sx_nx;
      sy    <= sy_nx;
      hsync <= (sx_nx >= HS_STA && sx_nx <= HS_END) ? H_POL : ~H_POL;
      vsync <= (sy_nx >= VS_STA && sy_nx <= VS_END) ? V_POL : ~V_POL;
      de    <= (sx_nx < H_ACT) && (sy_nx < V_ACT);
      frame <= (sx_nx == '0) && (sy_nx == '0);
      line  <= (sx_nx == '0);
    end
  end
endmodule

// File: tb/tb_display_timings_480p.sv
// Bench for display_timings_480p: default 480p instance plus a small, inverted-polarity instance
// used for whole-frame and vertical checks within a short run.
module tb_display_timings_480p;
  localparam int HT_A = 800, VT_A = 525, FT_A = HT_A * VT_A;
  localparam int HR_B = 16, HF_B = 2, HS_B = 4, HB_B = 3;
  localparam int VR_B = 8, VF_B = 2, VS_B = 2, VB_B = 3;
  localparam int HT_B = HR_B + HF_B + HS_B + HB_B;
  localparam int VT_B = VR_B + VF_B + VS_B + VB_B;
  localparam int FT_B = HT_B * VT_B;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic hs, vs, de, fr, ln;
  } obs_t;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic rst_a_n, rst_b_n;
  logic [9:0] sx_a, sy_a;
  logic [5:0] sx_b, sy_b;
  logic hsync_a, vsync_a, de_a, frame_a, line_a;
  logic hsync_b, vsync_b, de_b, frame_b, line_b;

  display_timings_480p u_dut_a (
    .clk_pix(clk_pix), .rst_pix_n(rst_a_n), .sx(sx_a), .sy(sy_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame(frame_a), .line(line_a)
  );

  display_timings_480p #(
    .CORDW(6), .H_RES(HR_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_RES(VR_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B), .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut_b (
    .clk_pix(clk_pix), .rst_pix_n(rst_b_n), .sx(sx_b), .sy(sy_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame(frame_b), .line(line_b)
  );

  obs_t q_a[$], q_b[$];
  int checks = 0, errors = 0;
  int t_a = 0, t_b = 0, cyc = 0;
  // per-window statistics gathered from observed outputs
  int de_a_n, hs_a_n, hs_a_first, ln_a_n, ln_a_last, ln_a_per, fr_a_n, inv_a;
  int de_b_n, hs_b_n, hs_b_first, vs_b_n, vs_b_fsx, vs_b_fsy;
  int ln_b_n, fr_b_n, fr_b_last, fr_b_per, inv_b;

  // expected outputs for absolute frame position t (cycles since (0,0))
  function automatic obs_t model(int t, int ht, int hr, int hsa, int hse,
                                 int vr, int vsa, int vse, bit hp, bit vp);
    obs_t o;
    int x, y;
    x = t % ht;
    y = t / ht;
    o.sx = 10'(x);
    o.sy = 10'(y);
    o.hs = (x >= hsa && x < hse) ? hp : ~hp;
    o.vs = (y >= vsa && y < vse) ? vp : ~vp;
    o.de = (x < hr) && (y < vr);
    o.fr = (t == 0);
    o.ln = (x == 0);
    return o;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_obs(string tag, obs_t o, obs_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed sx=%0d sy=%0d hs%b vs%b de%b fr%b ln%b expected sx=%0d sy=%0d hs%b vs%b de%b fr%b ln%b",
             tag, cyc, o.sx, o.sy, o.hs, o.vs, o.de, o.fr, o.ln, e.sx, e.sy, e.hs, e.vs, e.de, e.fr, e.ln);
    end
  endtask

  task automatic clr_stats();
    de_a_n = 0; hs_a_n = 0; hs_a_first = -1; ln_a_n = 0; ln_a_last = -1; ln_a_per = 0; fr_a_n = 0;
    de_b_n = 0; hs_b_n = 0; hs_b_first = -1; vs_b_n = 0; vs_b_fsx = -1; vs_b_fsy = -1;
    ln_b_n = 0; fr_b_n = 0; fr_b_last = -1; fr_b_per = 0;
  endtask

  // one clock: push expectations for the coming edge, then pop and compare after it
  task automatic step();
    obs_t oa, ob;
    t_a = rst_a_n ? (t_a + 1) % FT_A : FT_A - 1;
    t_b = rst_b_n ? (t_b + 1) % FT_B : FT_B - 1;
    q_a.push_back(model(t_a, HT_A, 640, 656, 752, 480, 490, 492, 1'b0, 1'b0));
    q_b.push_back(model(t_b, HT_B, HR_B, HR_B + HF_B, HR_B + HF_B + HS_B,
                        VR_B, VR_B + VF_B, VR_B + VF_B + VS_B, 1'b1, 1'b1));
    @(posedge clk_pix);
    #1;
    cyc++;
    oa = '{sx: sx_a, sy: sy_a, hs: hsync_a, vs: vsync_a, de: de_a, fr: frame_a, ln: line_a};
    ob = '{sx: {4'b0, sx_b}, sy: {4'b0, sy_b}, hs: hsync_b, vs: vsync_b, de: de_b, fr: frame_b, ln: line_b};
    chk_obs("sb_a", oa, q_a.pop_front());
    chk_obs("sb_b", ob, q_b.pop_front());
    if (oa.de) de_a_n++;
    if (!oa.hs) begin if (hs_a_first < 0) hs_a_first = int'(oa.sx); hs_a_n++; end
    if (oa.ln) begin ln_a_n++; if (ln_a_last >= 0) ln_a_per = cyc - ln_a_last; ln_a_last = cyc; end
    if (oa.fr) fr_a_n++;
    if (oa.sx >= HT_A || oa.sy >= VT_A || (oa.fr && !oa.ln) || (oa.ln && oa.sx != 0) ||
        (oa.de && (!oa.hs || !oa.vs))) inv_a++;
    if (ob.de) de_b_n++;
    if (ob.hs) begin if (hs_b_first < 0) hs_b_first = int'(ob.sx); hs_b_n++; end
    if (ob.vs) begin
      if (vs_b_fsx < 0) begin vs_b_fsx = int'(ob.sx); vs_b_fsy = int'(ob.sy); end
      vs_b_n++;
    end
    if (ob.ln) ln_b_n++;
    if (ob.fr) begin fr_b_n++; if (fr_b_last >= 0) fr_b_per = cyc - fr_b_last; fr_b_last = cyc; end
    if (ob.sx >= HT_B || ob.sy >= VT_B || (ob.fr && !ob.ln) || (ob.ln && ob.sx != 0) ||
        (ob.de && (ob.hs || ob.vs))) inv_b++;
  endtask

  initial begin
    int guard;
    inv_a = 0; inv_b = 0;
    clr_stats();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;

    // reset hold
    repeat (5) step();
    chk("rst_sx_a", int'(sx_a), 799);
    chk("rst_sy_a", int'(sy_a), 524);
    chk("rst_flags_a", int'({hsync_a, vsync_a, de_a, frame_a, line_a}), 5'b11000);
    chk("rst_flags_b", int'({hsync_b, vsync_b, de_b, frame_b, line_b}), 5'b00000);
    chk("rst_strobes_a", fr_a_n + ln_a_n + de_a_n, 0);

    // release: first cycle is (0,0) with frame, then one full line
    clr_stats();
    rst_a_n = 1'b1;
    step();
    chk("rel_sx_a", int'(sx_a), 0);
    chk("rel_sy_a", int'(sy_a), 0);
    chk("rel_frame_de_a", int'({frame_a, de_a, line_a}), 3'b111);
    repeat (799) step();
    chk("line_de_a", de_a_n, 640);
    chk("line_hs_len_a", hs_a_n, 96);
    chk("line_hs_start_a", hs_a_first, 656);
    chk("line_cnt_a", ln_a_n, 1);
    step();
    chk("line_period_a", ln_a_per, 800);
    chk("line2_sy_a", int'(sy_a), 1);

    // mid-frame reset pulse at (300,1)
    guard = 0;
    while (t_a != HT_A + 299 && guard < 2000) begin step(); guard++; end
    chk("reach_pos_a", guard < 2000 ? 1 : 0, 1);
    step();
    chk("pre_rst_sx_a", int'(sx_a), 300);
    clr_stats();
    rst_a_n = 1'b0;
    step();
    chk("mid_rst_sx_a", int'(sx_a), 799);
    chk("mid_rst_sy_a", int'(sy_a), 524);
    chk("mid_rst_nofr_a", fr_a_n + ln_a_n, 0);
    rst_a_n = 1'b1;
    step();
    chk("mid_rel_a", int'({frame_a, sx_a, sy_a}), {1'b1, 20'd0});
    chk("mid_rel_frcnt_a", fr_a_n, 1);

    // small inverted-polarity instance: three full frames
    clr_stats();
    rst_b_n = 1'b1;
    repeat (3 * FT_B) step();
    chk("frm_cnt_b", fr_b_n, 3);
    chk("frm_period_b", fr_b_per, FT_B);
    chk("frm_lines_b", ln_b_n, 3 * VT_B);
    chk("frm_de_b", de_b_n, 3 * HR_B * VR_B);
    chk("frm_hs_b", hs_b_n, 3 * VT_B * HS_B);
    chk("frm_hs_start_b", hs_b_first, HR_B + HF_B);
    chk("frm_vs_b", vs_b_n, 3 * VS_B * HT_B);
    chk("frm_vs_pos_b", vs_b_fsx * 100 + vs_b_fsy, VR_B + VF_B);

    // mid-frame reset on the small instance at (7,5)
    guard = 0;
    while (t_b != 5 * HT_B + 6 && guard < 2 * FT_B) begin step(); guard++; end
    chk("reach_pos_b", guard < 2 * FT_B ? 1 : 0, 1);
    step();
    clr_stats();
    rst_b_n = 1'b0;
    step();
    chk("mid_rst_pos_b", int'({sx_b, sy_b}), {6'(HT_B - 1), 6'(VT_B - 1)});
    chk("mid_rst_idle_b", int'({hsync_b, vsync_b, de_b, frame_b, line_b}), 0);
    rst_b_n = 1'b1;
    step();
    chk("mid_rel_b", int'({frame_b, line_b, de_b, sx_b, sy_b}), {3'b111, 12'd0});
    chk("mid_rel_frcnt_b", fr_b_n, 1);

    chk("invariants_a", inv_a, 0);
    chk("invariants_b", inv_b, 0);
    chk("sb_drained", q_a.size() + q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
